// File: rtl/expr_token_collector.sv
// Debounces recogniser tokens and sequences digit/operator/digit/'=' into a held expression.
// Optional build macro TOKEN_TIMEOUT_EN abandons a partial expression after TIMEOUT_CYC idle cycles.
module expr_token_collector #(
    parameter int unsigned STABLE_CNT  = 4,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tok_valid,
    input  logic [3:0] tok_code,
    input  logic       clear,
    output logic [3:0] shape_1,
    output logic [3:0] shape_2,
    output logic [1:0] shape_sym,
    output logic       expr_valid,
    output logic       tok_ack,
    output logic       err,
    output logic [2:0] state_dbg
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        S_A    = 3'b000,
        S_OP   = 3'b001,
        S_B    = 3'b010,
        S_EQ   = 3'b011,
        S_DONE = 3'b100
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               r_armed;
    logic [3:0]         r_prev_code;
    logic               w_accept;
    logic               w_timeout;

    logic [3:0]         r_shape_1, w_shape_1_next;
    logic [3:0]         r_shape_2, w_shape_2_next;
    logic [1:0]         r_sym, w_sym_next;
    logic               r_expr_valid, w_expr_valid_next;
    logic               r_tok_ack, w_tok_ack_next;
    logic               r_err, w_err_next;

    logic               w_is_digit;
    logic               w_is_op;
    logic               w_is_eq;
    logic [1:0]         w_sym_code;

    assign w_is_digit = (tok_code <= 4'd9);
    assign w_is_op    = (tok_code >= 4'd10) && (tok_code <= 4'd12);
    assign w_is_eq    = (tok_code == 4'd13);
    assign w_sym_code = 2'(tok_code - 4'd9);

    // Stability counter: reload on a new code or first valid cycle, accept on reaching STABLE_CNT.
    always_comb begin
        w_cnt_next = r_cnt;
        w_accept   = 1'b0;
        if (r_armed && tok_valid) begin
            if ((r_cnt == '0) || (tok_code != r_prev_code)) begin
                w_cnt_next = CNT_W'(1);
            end else begin
                w_cnt_next = r_cnt + CNT_W'(1);
            end
            w_accept = (w_cnt_next == CNT_W'(STABLE_CNT));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_armed     <= 1'b1;
            r_prev_code <= '0;
        end else begin
            if (tok_valid) begin
                r_prev_code <= tok_code;
            end
            if (clear) begin
                // A token accepted under clear is consumed so it is not counted again.
                r_cnt <= '0;
                if (w_accept) begin
                    r_armed <= 1'b0;
                end
            end else if (r_armed) begin
                r_cnt <= tok_valid ? w_cnt_next : '0;
                if (w_accept) begin
                    r_armed <= 1'b0;
                end
            end else if (!tok_valid) begin
                r_armed <= 1'b1;
                r_cnt   <= '0;
            end
        end
    end

`ifdef TOKEN_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            w_mid;

    assign w_mid     = (r_state == S_OP) || (r_state == S_B) || (r_state == S_EQ);
    assign w_timeout = w_mid && !w_accept && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_to_cnt <= '0;
        end else if (w_accept || !w_mid || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Expression sequencer: next state and next output values.
    always_comb begin
        w_state_next      = r_state;
        w_shape_1_next    = r_shape_1;
        w_shape_2_next    = r_shape_2;
        w_sym_next        = r_sym;
        w_expr_valid_next = r_expr_valid;
        w_tok_ack_next    = 1'b0;
        w_err_next        = 1'b0;

        if (clear) begin
            w_state_next      = S_A;
            w_shape_1_next    = '0;
            w_shape_2_next    = '0;
            w_sym_next        = '0;
            w_expr_valid_next = 1'b0;
        end else if (w_timeout) begin
            w_state_next   = S_A;
            w_shape_1_next = '0;
            w_shape_2_next = '0;
            w_sym_next     = '0;
            w_err_next     = 1'b1;
        end else if (w_accept) begin
            if (!(w_is_digit || w_is_op || w_is_eq)) begin
                w_err_next = 1'b1;
            end else begin
                case (r_state)
                    S_A: begin
                        if (w_is_digit) begin
                            w_shape_1_next = tok_code;
                            w_state_next   = S_OP;
                            w_tok_ack_next = 1'b1;
                        end else begin
                            w_err_next = 1'b1;
                        end
                    end
                    S_OP: begin
                        if (w_is_op) begin
                            w_sym_next     = w_sym_code;
                            w_state_next   = S_B;
                            w_tok_ack_next = 1'b1;
                        end else if (w_is_digit) begin
                            w_shape_1_next = tok_code;
                            w_tok_ack_next = 1'b1;
                        end else begin
                            w_err_next = 1'b1;
                        end
                    end
                    S_B: begin
                        if (w_is_digit) begin
                            w_shape_2_next = tok_code;
                            w_state_next   = S_EQ;
                            w_tok_ack_next = 1'b1;
                        end else if (w_is_op) begin
                            w_sym_next     = w_sym_code;
                            w_tok_ack_next = 1'b1;
                        end else begin
                            w_err_next = 1'b1;
                        end
                    end
                    S_EQ: begin
                        if (w_is_eq) begin
                            w_expr_valid_next = 1'b1;
                            w_state_next      = S_DONE;
                            w_tok_ack_next    = 1'b1;
                        end else if (w_is_digit) begin
                            w_shape_2_next = tok_code;
                            w_tok_ack_next = 1'b1;
                        end else begin
                            w_err_next = 1'b1;
                        end
                    end
                    S_DONE: begin
                        if (w_is_digit) begin
                            w_expr_valid_next = 1'b0;
                            w_shape_1_next    = tok_code;
                            w_shape_2_next    = '0;
                            w_sym_next        = '0;
                            w_state_next      = S_OP;
                            w_tok_ack_next    = 1'b1;
                        end else begin
                            w_err_next = 1'b1;
                        end
                    end
                    default: w_state_next = S_A;
                endcase
            end
        end else if (!(r_state inside {S_A, S_OP, S_B, S_EQ, S_DONE})) begin
            w_state_next = S_A;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_A;
            r_shape_1    <= '0;
            r_shape_2    <= '0;
            r_sym        <= '0;
            r_expr_valid <= 1'b0;
            r_tok_ack    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_shape_1    <= w_shape_1_next;
            r_shape_2    <= w_shape_2_next;
            r_sym        <= w_sym_next;
            r_expr_valid <= w_expr_valid_next;
            r_tok_ack    <= w_tok_ack_next;
            r_err        <= w_err_next;
        end
    end

    assign shape_1    = r_shape_1;
    assign shape_2    = r_shape_2;
    assign shape_sym  = r_sym;
    assign expr_valid = r_expr_valid;
    assign tok_ack    = r_tok_ack;
    assign err        = r_err;
    assign state_dbg  = r_state;

endmodule

// File: doc/expr_token_collector.md
Name: expr_token_collector

Overview:
- Upstream of the arithmetic stage.
- Turns the recogniser's per-frame token stream (digits 0-9, operators, '=') into a stable expression: operand 1, operator, operand 2.
- Debounces each token.
- Sequences digit / operator / digit / '=' with a state machine.
- Holds the captured operands and operator steady for the arithmetic stage, which converts the result to tens/ones digits.

Parameters:
- STABLE_CNT, 4: consecutive cycles a token must be held (valid, same code) before it is accepted; legal range 1..255.
- TIMEOUT_CYC, 1000000: idle cycles mid-expression before abandoning it (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- tok_valid  in  1  recogniser currently sees a token
- tok_code  in  4  0-9 digit; 10 '+'; 11 '-'; 12 '*'; 13 '='; 14-15 illegal
- clear  in  1  synchronous abort, returns to S_A
- shape_1  out  4  first operand digit
- shape_2  out  4  second operand digit
- shape_sym  out  2  01 add, 10 sub, 11 mul, 00 none
- expr_valid  out  1  level; high while a complete expression is held
- tok_ack  out  1  1-cycle pulse per accepted token
- err  out  1  1-cycle pulse on a rejected token
- state_dbg  out  3  current state encoding

Behaviour:
- Reset (rst_n=0 at clk edge):
  - shape_1=0, shape_2=0, shape_sym=00, expr_valid=0, tok_ack=0, err=0.
  - State S_A (000); stability counter 0; armed=1; timeout counter 0.
- Debounce:
  - While armed and tok_valid=1, the counter increments when tok_code equals the previous cycle's code. It reloads to 1 when the code changes or on the first valid cycle.
  - On the cycle the counter reaches STABLE_CNT, the token is accepted. Acceptance happens in that same cycle, so tok_ack is registered and appears 1 cycle after the STABLE_CNT-th valid sample.
  - After acceptance, armed=0. The counter stays frozen until tok_valid=0 for at least 1 cycle, which sets armed=1 and the counter to 0.
  - A held token is therefore accepted exactly once.
  - tok_valid=0 while armed resets the counter to 0.
- Codes 14-15 are illegal. When stable they produce err, do not change state, and still disarm.
- State machine, applied only on an accepted token. Codes 0-9 are digits; codes 10-12 are operators.
  - S_A (000):
    - digit: shape_1<=code, go to S_OP.
    - operator or '=': err.
  - S_OP (001):
    - operator: shape_sym<=01/10/11 for 10/11/12, go to S_B.
    - digit: shape_1<=code (correction), tok_ack, stay.
    - '=': err.
  - S_B (010):
    - digit: shape_2<=code, go to S_EQ.
    - operator: shape_sym replaced, stay.
    - '=': err.
  - S_EQ (011):
    - '=': expr_valid<=1, go to S_DONE.
    - digit: shape_2 replaced, stay.
    - operator: err.
  - S_DONE (100):
    - digit: expr_valid<=0, shape_1<=code, shape_2<=0, shape_sym<=00, go to S_OP. Chained new expression.
    - operator or '=': err; outputs held.
- Every accepted legal transition or correction pulses tok_ack. err and tok_ack are never high together.
- Outputs change only on an accepted token or on clear/reset. They are stable for any number of cycles in S_DONE.
- Priority: rst_n > clear > timeout > token.
  - clear has the same effect as reset, except that armed is kept at its current value.
  - clear and a token accepted in the same cycle: clear wins and the token is consumed, not replayed.
- Unused state encodings 101-111 return to S_A on the next clock.

Optional Feature:
- Macro TOKEN_TIMEOUT_EN.
- When defined:
  - A counter of ceil(log2(TIMEOUT_CYC+1)) bits increments each cycle the state is S_OP, S_B or S_EQ with no accepted token.
  - It resets on any accepted token or on entering S_A/S_DONE.
  - On reaching TIMEOUT_CYC it pulses err, returns to S_A, and clears shape_1, shape_2 and shape_sym.
- When undefined:
  - No counter is instantiated.
  - A partial expression is held indefinitely.

Test Plan:
- Reset then token sequence 7, '+', 5, '=' (each held 6 cycles, 2-cycle gap, STABLE_CNT=4):
  - 4 tok_ack pulses.
  - shape_1=7, shape_sym=01, shape_2=5, expr_valid=1, state_dbg=100.
- Token 3 held 50 cycles, no gap, then 3 again after a gap:
  - First hold gives 1 tok_ack, shape_1=3, state S_OP.
  - Second gives another tok_ack; shape_1 stays 3 (correction).
- Code toggling 4,9,4,9 each cycle for 20 cycles: no tok_ack, no err, state S_A.
- In S_A, '*' held 5 cycles: err one pulse, state S_A, shape_sym=00.
- From S_DONE (9*9=), digit 2 accepted:
  - expr_valid drops on the same edge tok_ack rises.
  - shape_1=2, shape_2=0, shape_sym=00, state S_OP.
- With TOKEN_TIMEOUT_EN and TIMEOUT_CYC=16: accept 6 and '-', then idle 16 cycles → err pulse, state S_A, all operands 0. clear asserted mid-S_B → S_A next cycle, expr_valid=0.
